// File: rtl/dma_priority_arbiter_n_if.sv
// Request/grant bundle between the DMA channel logic and the priority arbiter.
interface dma_priority_arbiter_n_if #(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
);
  logic              CS_N;
  logic [NUM_CH-1:0] DREQ;
  logic              dreq_sense;
  logic              dack_sense;
  logic              rotating;
  logic [NUM_CH-1:0] mask;
  logic [NUM_CH-1:0] tc_status;
  logic              sw_req_set;
  logic [CH_W-1:0]   sw_req_ch;
  logic              arb_en;
  logic              ld_ack;
  logic              xfer_done;
  logic [NUM_CH-1:0] dma_req;
  logic [NUM_CH-1:0] DACK;
  logic              grant_valid;
  logic [CH_W-1:0]   active_ch;

  modport slave (
    input  CS_N, DREQ, dreq_sense, dack_sense, rotating, mask, tc_status,
           sw_req_set, sw_req_ch, arb_en, ld_ack, xfer_done,
    output dma_req, DACK, grant_valid, active_ch
  );
  modport master (
    output CS_N, DREQ, dreq_sense, dack_sense, rotating, mask, tc_status,
           sw_req_set, sw_req_ch, arb_en, ld_ack, xfer_done,
    input  dma_req, DACK, grant_valid, active_ch
  );
endinterface

// File: rtl/dma_priority_arbiter_n.sv
// N-channel DMA priority arbiter: qualifies requests per channel, grants one
// by fixed or rotating priority and holds it until completion or abandon.
module dma_arb_ch (
  input  logic CLK,
  input  logic RESET,
  input  logic dreq,
  input  logic dreqSense,
  input  logic mask,
  input  logic tc,
  input  logic swSet,
  input  logic swClr,
  input  logic granted,
  input  logic ldAck,
  input  logic dackSense,
  output logic chanReq,
  output logic dack
);
  logic swReq;

  // A set in the same cycle as the completion clear must win.
  always_ff @(posedge CLK) begin
    if (RESET)      swReq <= 1'b0;
    else if (swSet) swReq <= 1'b1;
    else if (swClr) swReq <= 1'b0;
  end

  assign chanReq = (((dreqSense ? dreq : ~dreq) & ~mask) | swReq) & ~tc;
  assign dack    = (granted & ldAck) ? dackSense : ~dackSense;
endmodule

module dma_priority_arbiter_n #(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input logic                  CLK,
  input logic                  RESET,
  dma_priority_arbiter_n_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state, stateNxt;
  logic [CH_W-1:0]   activeCh, activeChNxt;
  logic [CH_W-1:0]   topQ, topQNxt;
  logic [CH_W-1:0]   winner;
  logic [NUM_CH-1:0] chanReq;
  logic [NUM_CH-1:0] dack;
  logic              anyReq;
  logic              swClrEn;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    dma_arb_ch u_ch (
      .CLK       (CLK),
      .RESET     (RESET),
      .dreq      (bus.DREQ[i]),
      .dreqSense (bus.dreq_sense),
      .mask      (bus.mask[i]),
      .tc        (bus.tc_status[i]),
      .swSet     (bus.sw_req_set && (bus.sw_req_ch == CH_W'(i))),
      .swClr     (swClrEn && (activeCh == CH_W'(i))),
      .granted   ((state == GRANT) && (activeCh == CH_W'(i))),
      .ldAck     (bus.ld_ack),
      .dackSense (bus.dack_sense),
      .chanReq   (chanReq[i]),
      .dack      (dack[i])
    );
  end

  assign anyReq = |chanReq;

  // Circular search starting at topQ; first requesting channel wins.
  always_comb begin
    int  idx;
    logic found;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(topQ) + i) % NUM_CH;
      if (!found && chanReq[idx]) begin
        winner = CH_W'(idx);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    stateNxt    = state;
    activeChNxt = activeCh;
    topQNxt     = bus.rotating ? topQ : '0;
    swClrEn     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.arb_en) begin
          if (anyReq) begin
            activeChNxt = winner;
            stateNxt    = GRANT;
          end else begin
            topQNxt = '0;
          end
        end
      end
      GRANT: begin
        if (bus.xfer_done) begin
          swClrEn  = 1'b1;
          stateNxt = IDLE;
          if (bus.rotating)
            topQNxt = (activeCh == CH_W'(NUM_CH - 1)) ? '0 : activeCh + CH_W'(1);
        end else if (!chanReq[activeCh]) begin
          stateNxt = IDLE;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      activeCh <= '0;
      topQ     <= '0;
    end else begin
      state    <= stateNxt;
      activeCh <= activeChNxt;
      topQ     <= topQNxt;
    end
  end

  assign bus.dma_req     = bus.CS_N ? chanReq : '0;
  assign bus.DACK        = dack;
  assign bus.grant_valid = (state == GRANT);
  assign bus.active_ch   = activeCh;
endmodule

// File: doc/dma_priority_arbiter_n.md
Name: dma_priority_arbiter_n

Overview:
- Parametrised N-channel successor of the 4-channel DMA priority logic.
- Combines hardware DREQ (programmable sense), mask, software requests and terminal-count exclusion.
- Grants one channel using fixed or rotating priority and holds the grant through a transfer handshake.
- Drives sense-programmable DACK; the arbitration/hold state machine is clocked by the single system clock instead of a strobe edge.

Parameters:
- NUM_CH, 4: number of DMA channels, 2..16.
- CH_W, $clog2(NUM_CH): channel index width (derived; do not override).

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- CS_N  in  1  chip select, active low; dma_req is visible only while CS_N=1.
- DREQ  in  NUM_CH  raw channel requests.
- dreq_sense  in  1  1: DREQ active-high; 0: DREQ active-low.
- dack_sense  in  1  1: DACK active-high; 0: DACK active-low.
- rotating  in  1  1: rotating priority; 0: fixed priority, channel 0 highest.
- mask  in  NUM_CH  1 blocks the hardware DREQ of that channel.
- tc_status  in  NUM_CH  1 means the channel has reached TC; it is excluded from arbitration.
- sw_req_set  in  1  one-cycle pulse that sets the software request bit sw_req_ch.
- sw_req_ch  in  CH_W  target channel for sw_req_set.
- arb_en  in  1  one-cycle arbitration strobe.
- ld_ack  in  1  enables DACK output while a grant is held.
- xfer_done  in  1  one-cycle pulse marking the end of the granted service.
- dma_req  out  NUM_CH  qualified request vector.
- DACK  out  NUM_CH  acknowledge outputs.
- grant_valid  out  1  a grant is held.
- active_ch  out  CH_W  index of the granted channel.

Behaviour:
- chan_req = ((dreq_sense ? DREQ : ~DREQ) & ~mask | sw_req_q) & ~tc_status. It is combinational.
- dma_req = CS_N ? chan_req : 0.
- sw_req_q[NUM_CH] is a register.
  - sw_req_set sets bit sw_req_ch.
  - sw_req_ch >= NUM_CH is ignored.
  - A bit is cleared by xfer_done for the granted channel.
  - Set and clear of the same bit in the same cycle: set wins.
- top_q[CH_W] is the highest-priority channel.
  - Search order: top_q, top_q+1, ... mod NUM_CH.
  - rotating=0: top_q is forced to 0 every cycle.
  - rotating=1, on a normal completion of channel k: top_q <= (k+1) mod NUM_CH, wrapping from NUM_CH-1 to 0.
- FSM states are IDLE and GRANT.
- IDLE:
  - grant_valid=0.
  - On arb_en with |chan_req, latch the winner into active_ch and go to GRANT. grant_valid rises the cycle after arb_en (1-cycle latency).
  - arb_en with chan_req==0: stay in IDLE. active_ch holds its value and top_q resets to 0.
- GRANT:
  - grant_valid=1 and active_ch is stable. Further arb_en pulses are ignored; requests from other channels do not preempt.
  - xfer_done: clear the granted channel's sw_req_q bit, update top_q, go to IDLE. grant_valid falls the next cycle.
  - Abandon: if chan_req[active_ch] is 0 while xfer_done is 0 (masked, TC, DREQ drop), go to IDLE next cycle. No rotation and no sw_req_q clear.
  - xfer_done and a dropped request in the same cycle count as a normal completion.
- DACK:
  - Inactive level is ~dack_sense for every bit.
  - Only in GRANT with ld_ack=1 does bit active_ch take the active level dack_sense.
  - DACK is combinational from state, active_ch, ld_ack and dack_sense.
- arb_en and xfer_done in the same IDLE cycle: xfer_done is ignored and arbitration proceeds.
- Reset values, including RESET asserted mid-GRANT: state=IDLE, grant_valid=0, active_ch=0, top_q=0, sw_req_q=0, all DACK inactive (=~dack_sense).
- Reset overrides every concurrent input in that cycle.

Test Plan:
- NUM_CH=4, rotating=0, dreq_sense=1, DREQ=4'b1010, arb_en pulse -> next cycle grant_valid=1, active_ch=1. With ld_ack=1 and dack_sense=1, DACK=4'b0010. xfer_done -> grant_valid=0, and a new arb_en grants channel 1 again.
- NUM_CH=4, rotating=1, DREQ=4'b1111, four arb_en/xfer_done rounds -> active_ch sequence 0,1,2,3, then 0 again (wrap).
- dreq_sense=0, dack_sense=0, DREQ=4'b1011, mask=0 -> chan_req=4'b0100, active_ch=2, DACK=4'b1011. CS_N=0 -> dma_req=0, while the grant still works.
- In GRANT on channel 2, set mask[2]=1 with xfer_done=0 -> IDLE next cycle, grant_valid=0, top_q unchanged. Next arbitration with all requests picks the same order as before.
- sw_req_set with sw_req_ch=3, DREQ=0, tc_status=4'b0000 -> grant channel 3. On xfer_done, sw_req_q[3] clears. Repeat with tc_status[3]=1 -> no grant, dma_req=0.
- NUM_CH=8, rotating=1, DREQ=8'h81, top_q=7 -> grant 7, then 0. RESET asserted mid-GRANT -> next cycle grant_valid=0, active_ch=0, DACK all inactive, sw_req_q=0.
